// File: rtl/system_bus_arbiter_pkg.sv
// Shared SystemBus arbiter types: FSM state, registered request record, line-compare helper.
// Request fields are sized to the widest supported bus; the arbiter uses only the low bits it needs.
package system_bus_arbiter_pkg;

  localparam int SYSBUS_ADDR_MAX = 64;
  localparam int SYSBUS_DATA_MAX = 512;
  localparam int SYSBUS_MASK_MAX = SYSBUS_DATA_MAX / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ArbState;

  typedef struct packed {
    logic                       we;
    logic                       ce;
    logic [SYSBUS_ADDR_MAX-1:0] addr;
    logic [SYSBUS_MASK_MAX-1:0] mask;
    logic [SYSBUS_DATA_MAX-1:0] data;
  } RwRequest;

  // True when both addresses fall in the same bus line of 2**off_w bytes.
  function automatic logic line_match(input logic [SYSBUS_ADDR_MAX-1:0] a,
                                      input logic [SYSBUS_ADDR_MAX-1:0] b,
                                      input int                         off_w);
    return (a >> off_w) == (b >> off_w);
  endfunction

endpackage

// File: rtl/system_bus_arbiter_if.sv
// Arbiter bus bundle: N user ports and one provider port, read/write plus invalidation channels.
// master = arbiter view, slave = users + provider view.
interface system_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int N_USERS    = 2
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic [N_USERS-1:0]            u_rw_valid;
  logic [N_USERS-1:0]            u_rw_we;
  logic [N_USERS-1:0]            u_w_ce;
  logic [N_USERS*ADDR_WIDTH-1:0] u_rw_addr;
  logic [N_USERS*MASK_WIDTH-1:0] u_w_mask;
  logic [N_USERS*DATA_WIDTH-1:0] u_w_data;
  logic [N_USERS-1:0]            u_rw_ready;
  logic [DATA_WIDTH-1:0]         u_r_data;
  logic [N_USERS-1:0]            u_inv_valid;
  logic [ADDR_WIDTH-1:0]         u_inv_addr;
  logic [N_USERS-1:0]            u_inv_ready;

  logic                          p_rw_valid;
  logic                          p_rw_we;
  logic                          p_w_ce;
  logic [ADDR_WIDTH-1:0]         p_rw_addr;
  logic [MASK_WIDTH-1:0]         p_w_mask;
  logic [DATA_WIDTH-1:0]         p_w_data;
  logic                          p_rw_ready;
  logic [DATA_WIDTH-1:0]         p_r_data;
  logic                          p_inv_valid;
  logic [ADDR_WIDTH-1:0]         p_inv_addr;
  logic                          p_inv_ready;

  modport master (
    input  u_rw_valid, u_rw_we, u_w_ce, u_rw_addr, u_w_mask, u_w_data, u_inv_ready,
    input  p_rw_ready, p_r_data, p_inv_valid, p_inv_addr,
    output u_rw_ready, u_r_data, u_inv_valid, u_inv_addr,
    output p_rw_valid, p_rw_we, p_w_ce, p_rw_addr, p_w_mask, p_w_data, p_inv_ready
  );

  modport slave (
    output u_rw_valid, u_rw_we, u_w_ce, u_rw_addr, u_w_mask, u_w_data, u_inv_ready,
    output p_rw_ready, p_r_data, p_inv_valid, p_inv_addr,
    input  u_rw_ready, u_r_data, u_inv_valid, u_inv_addr,
    input  p_rw_valid, p_rw_we, p_w_ce, p_rw_addr, p_w_mask, p_w_data, p_inv_ready
  );

endinterface

// File: rtl/system_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after (last_i+1) mod N, wrapping.
// Purely combinational; no state, no backpressure.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  always_comb begin
    int c;
    c         = 0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = int'(last_i) + k;
      if (c >= N) c = c - N;
      if (!gnt_vld_o && req_i[c]) begin
        gnt_vld_o   = 1'b1;
        gnt_idx_o   = IDX_W'(c);
        gnt_oh_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/system_bus_arbiter.sv
// Round-robin N-user to single-provider SystemBus arbiter with an invalidation broadcast channel.
// Optional SYSBUS_ARB_INV_BLOCK_EN: hold off grants that hit the line of a pending invalidation.
module system_bus_arbiter
  import system_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int N_USERS    = 2
) (
  input logic                 clk,
  input logic                 rst,
  system_bus_arbiter_if.master bus
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(N_USERS);
  localparam int OFF_W      = $clog2(MASK_WIDTH);

  ArbState              state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  RwRequest             req_q, req_d;
  RwRequest             pick_req;
  logic [N_USERS-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic                 grant_block;
  logic [N_USERS-1:0]   rw_done;

  logic                 inv_pend_q, inv_pend_d;
  logic [ADDR_WIDTH-1:0] inv_addr_q, inv_addr_d;
  logic [N_USERS-1:0]   ack_q, ack_d;
  logic [N_USERS-1:0]   inv_vld;
  logic                 inv_done;

  rr_picker #(
    .N     (N_USERS),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req_i     (bus.u_rw_valid),
    .last_i    (last_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .gnt_vld_o (pick_vld)
  );

  always_comb begin
    pick_req = '0;
    for (int i = 0; i < N_USERS; i++) begin
      if (pick_oh[i]) begin
        pick_req.we   = bus.u_rw_we[i];
        pick_req.ce   = bus.u_w_ce[i];
        pick_req.addr = SYSBUS_ADDR_MAX'(bus.u_rw_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        pick_req.mask = SYSBUS_MASK_MAX'(bus.u_w_mask[i*MASK_WIDTH +: MASK_WIDTH]);
        pick_req.data = SYSBUS_DATA_MAX'(bus.u_w_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

`ifdef SYSBUS_ARB_INV_BLOCK_EN
  always_comb begin
    grant_block = 1'b0;
    for (int i = 0; i < N_USERS; i++) begin
      if (inv_pend_q && bus.u_rw_valid[i] &&
          line_match(SYSBUS_ADDR_MAX'(bus.u_rw_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
                     SYSBUS_ADDR_MAX'(inv_addr_q), OFF_W)) begin
        grant_block = 1'b1;
      end
    end
  end
`else
  assign grant_block = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(N_USERS - 1);
      gnt_q      <= '0;
      req_q      <= '0;
      inv_pend_q <= 1'b0;
      inv_addr_q <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      req_q      <= req_d;
      inv_pend_q <= inv_pend_d;
      inv_addr_q <= inv_addr_d;
      ack_q      <= ack_d;
    end
  end

  // Completion pulses are suppressed under reset so an abandoned op never reports done.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    req_d   = req_q;
    rw_done = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld && !grant_block) begin
          state_d = BUSY;
          gnt_d   = pick_idx;
          last_d  = pick_idx;
          req_d   = pick_req;
        end
      end
      BUSY: begin
        if (bus.p_rw_ready) begin
          state_d        = IDLE;
          rw_done[gnt_q] = ~rst;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inv_vld = {N_USERS{inv_pend_q}} & ~ack_q;

  always_comb begin
    inv_pend_d = inv_pend_q;
    inv_addr_d = inv_addr_q;
    ack_d      = ack_q;
    inv_done   = 1'b0;
    if (!inv_pend_q) begin
      if (bus.p_inv_valid) begin
        inv_pend_d = 1'b1;
        inv_addr_d = bus.p_inv_addr;
        ack_d      = '0;
      end
    end else begin
      ack_d = ack_q | (bus.u_inv_ready & inv_vld);
      if (&ack_d) begin
        inv_done   = ~rst;
        inv_pend_d = 1'b0;
      end
    end
  end

  assign bus.p_rw_valid  = (state_q == BUSY);
  assign bus.p_rw_we     = req_q.we;
  assign bus.p_w_ce      = req_q.ce;
  assign bus.p_rw_addr   = ADDR_WIDTH'(req_q.addr);
  assign bus.p_w_mask    = MASK_WIDTH'(req_q.mask);
  assign bus.p_w_data    = DATA_WIDTH'(req_q.data);
  assign bus.u_rw_ready  = rw_done;
  assign bus.u_r_data    = bus.p_r_data;
  assign bus.u_inv_valid = inv_vld;
  assign bus.u_inv_addr  = inv_addr_q;
  assign bus.p_inv_ready = inv_done;

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Bench for system_bus_arbiter: directed scenarios then random traffic, all cycles checked
// against a transaction-level reference model of grants and invalidation broadcasts.
module tb_system_bus_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int MW  = DW / 8;
  localparam int OFF = $clog2(MW);
`ifdef SYSBUS_ARB_INV_BLOCK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  system_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_USERS(N)) bus ();

  system_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_USERS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: transaction view of the bus.
  bit            m_valid = 1'b0;
  bit            m_busy;
  int            m_owner, m_last;
  bit            m_we, m_ce;
  logic [AW-1:0] m_addr;
  logic [MW-1:0] m_mask;
  logic [DW-1:0] m_data;
  bit            m_pend;
  logic [AW-1:0] m_iaddr;
  bit            m_acked[N];
  int            glog[$];

  logic          obs_pvld, obs_we, obs_ce, obs_pir;
  logic [N-1:0]  obs_rdy, obs_iv;
  logic [AW-1:0] obs_addr, obs_iaddr;
  logic [MW-1:0] obs_mask;
  logic [DW-1:0] obs_data, obs_rdata;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input bit ce,
                         input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
    bus.u_rw_valid[i]         = v;
    bus.u_rw_we[i]            = we;
    bus.u_w_ce[i]             = ce;
    bus.u_rw_addr[i*AW +: AW] = a;
    bus.u_w_mask[i*MW +: MW]  = m;
    bus.u_w_data[i*DW +: DW]  = d;
  endtask

  function automatic bit model_blocked();
    bit b = 1'b0;
    if (BLK && m_pend)
      for (int i = 0; i < N; i++)
        if (bus.u_rw_valid[i] && ((bus.u_rw_addr[i*AW +: AW] >> OFF) == (m_iaddr >> OFF))) b = 1'b1;
    return b;
  endfunction

  // One clock: sample at negedge, compare with model, advance model, return just after posedge.
  task automatic cycle();
    logic [N-1:0] exp_rdy, exp_iv;
    bit all_ack;
    @(negedge clk);
    obs_pvld = bus.p_rw_valid; obs_we = bus.p_rw_we; obs_ce = bus.p_w_ce;
    obs_addr = bus.p_rw_addr; obs_mask = bus.p_w_mask; obs_data = bus.p_w_data;
    obs_rdy = bus.u_rw_ready; obs_rdata = bus.u_r_data; obs_iv = bus.u_inv_valid;
    obs_iaddr = bus.u_inv_addr; obs_pir = bus.p_inv_ready;
    for (int i = 0; i < N; i++) if (obs_rdy[i]) glog.push_back(i);
    if (m_valid) begin
      exp_rdy = '0;
      if (m_busy && bus.p_rw_ready && !rst) exp_rdy[m_owner] = 1'b1;
      check_eq("p_rw_valid", 64'(obs_pvld), 64'(m_busy));
      check_eq("u_rw_ready", 64'(obs_rdy), 64'(exp_rdy));
      if (m_busy) begin
        check_eq("p_rw_addr", 64'(obs_addr), 64'(m_addr));
        check_eq("p_rw_we", 64'(obs_we), 64'(m_we));
        check_eq("p_w_ce", 64'(obs_ce), 64'(m_ce));
        check_eq("p_w_mask", 64'(obs_mask), 64'(m_mask));
        check_eq("p_w_data", 64'(obs_data), 64'(m_data));
      end
      if (exp_rdy != '0) check_eq("u_r_data", 64'(obs_rdata), 64'(bus.p_r_data));
      all_ack = m_pend;
      for (int i = 0; i < N; i++) begin
        exp_iv[i] = m_pend && !m_acked[i];
        if (!(m_acked[i] || bus.u_inv_ready[i])) all_ack = 1'b0;
      end
      check_eq("u_inv_valid", 64'(obs_iv), 64'(exp_iv));
      if (m_pend) check_eq("u_inv_addr", 64'(obs_iaddr), 64'(m_iaddr));
      check_eq("p_inv_ready", 64'(obs_pir), 64'(all_ack && !rst));
    end
    if (rst) begin
      m_valid = 1'b1; m_busy = 1'b0; m_last = N - 1; m_pend = 1'b0;
      for (int i = 0; i < N; i++) m_acked[i] = 1'b0;
    end else begin
      if (m_busy) begin
        if (bus.p_rw_ready) m_busy = 1'b0;
      end else if (!model_blocked()) begin
        for (int k = 1; k <= N; k++) begin
          int u;
          u = (m_last + k) % N;
          if (bus.u_rw_valid[u]) begin
            m_busy = 1'b1; m_owner = u; m_last = u;
            m_we = bus.u_rw_we[u]; m_ce = bus.u_w_ce[u];
            m_addr = bus.u_rw_addr[u*AW +: AW]; m_mask = bus.u_w_mask[u*MW +: MW];
            m_data = bus.u_w_data[u*DW +: DW];
            break;
          end
        end
      end
      if (!m_pend) begin
        if (bus.p_inv_valid) begin
          m_pend = 1'b1; m_iaddr = bus.p_inv_addr;
          for (int i = 0; i < N; i++) m_acked[i] = 1'b0;
        end
      end else begin
        all_ack = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (bus.u_inv_ready[i]) m_acked[i] = 1'b1;
          if (!m_acked[i]) all_ack = 1'b0;
        end
        if (all_ack) m_pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input int i);
    logic [AW-1:0] a;
    case ($urandom % 4)
      0: a = 32'h2040;
      1: a = 32'h2047;
      2: a = 32'h2048;
      default: a = $urandom;
    endcase
    set_req(i, 1'b1, 1'($urandom), 1'($urandom), a, MW'($urandom), {$urandom, $urandom});
  endtask

  initial begin
    int  pir_cnt;
    bit  done;
    logic [N-1:0] rr_exp [4];
    rr_exp[0] = 3'b010; rr_exp[1] = 3'b001; rr_exp[2] = 3'b010; rr_exp[3] = 3'b001;

    rst = 1'b1;
    bus.u_rw_valid = '0; bus.u_rw_we = '0; bus.u_w_ce = '0; bus.u_rw_addr = '0;
    bus.u_w_mask = '0; bus.u_w_data = '0; bus.u_inv_ready = '0;
    bus.p_rw_ready = 1'b0; bus.p_r_data = '0; bus.p_inv_valid = 1'b0; bus.p_inv_addr = '0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    check_eq("rst_pvld", 64'(obs_pvld), 64'd0);
    check_eq("rst_rdy", 64'(obs_rdy), 64'd0);
    check_eq("rst_iv", 64'(obs_iv), 64'd0);
    check_eq("rst_pir", 64'(obs_pir), 64'd0);
    check_eq("rst_addr", 64'(obs_addr), 64'd0);
    check_eq("rst_wdata", 64'(obs_data), 64'd0);
    check_eq("rst_iaddr", 64'(obs_iaddr), 64'd0);

    // Single read by user 1, provider answers after three wait cycles.
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h1000, '0, '0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("rd_wait_rdy", 64'(obs_rdy), 64'd0);
    end
    check_eq("rd_addr", 64'(obs_addr), 64'h1000);
    check_eq("rd_pvld", 64'(obs_pvld), 64'd1);
    bus.p_rw_ready = 1'b1; bus.p_r_data = 64'hDEADBEEF_CAFEF00D;
    cycle();
    check_eq("rd_rdy", 64'(obs_rdy), 64'b010);
    check_eq("rd_data", 64'(obs_rdata), 64'hDEADBEEF_CAFEF00D);
    bus.p_rw_ready = 1'b0; set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle();
    check_eq("rd_one_pulse", 64'(obs_rdy), 64'd0);

    // Writes from user 0, chip enable set then clear.
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h3000, 8'h0F, 64'h11223344);
    cycle();
    bus.p_rw_ready = 1'b1;
    cycle();
    check_eq("wr_mask", 64'(obs_mask), 64'h0F);
    check_eq("wr_data", 64'(obs_data), 64'h11223344);
    check_eq("wr_we", 64'(obs_we), 64'd1);
    check_eq("wr_ce", 64'(obs_ce), 64'd1);
    check_eq("wr_rdy", 64'(obs_rdy), 64'b001);
    bus.p_rw_ready = 1'b0; set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle();
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h3008, 8'hF0, 64'h55);
    cycle();
    bus.p_rw_ready = 1'b1;
    cycle();
    check_eq("wr2_ce", 64'(obs_ce), 64'd0);
    bus.p_rw_ready = 1'b0; set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle();

    // Contention: users 0 and 1 always requesting, provider completes each op in one cycle.
    glog.delete();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h100, '0, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h200, '0, '0);
    for (int k = 0; k < 8; k++) begin
      bus.p_rw_ready = m_busy;
      cycle();
    end
    bus.p_rw_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0); set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle();
    check_eq("rr_count", 64'(glog.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < glog.size()) check_eq("rr_order", 64'(1 << glog[k]), 64'(rr_exp[k]));

    // Invalidation with staggered acknowledges.
    bus.p_inv_valid = 1'b1; bus.p_inv_addr = 32'h2040;
    cycle();
    bus.p_inv_valid = 1'b0;
    pir_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      bus.u_inv_ready = (c == 1) ? 3'b101 : (c == 4) ? 3'b010 : 3'b000;
      cycle();
      pir_cnt += int'(obs_pir);
      if (c == 1) begin
        check_eq("inv_c1_iv", 64'(obs_iv), 64'b111);
        check_eq("inv_addr", 64'(obs_iaddr), 64'h2040);
      end
      if (c == 2) check_eq("inv_c2_iv", 64'(obs_iv), 64'b010);
      if (c == 4) check_eq("inv_c4_pir", 64'(obs_pir), 64'd1);
      if (c == 5) check_eq("inv_c5_iv", 64'(obs_iv), 64'd0);
    end
    check_eq("inv_pir_pulses", 64'(pir_cnt), 64'd1);

    // Request to the line of a pending invalidation.
    bus.p_inv_valid = 1'b1; bus.p_inv_addr = 32'h2040;
    cycle();
    bus.p_inv_valid = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h2040, '0, '0);
    cycle();
    cycle();
    check_eq("blk_c2_pvld", 64'(obs_pvld), 64'(!BLK));
    bus.u_inv_ready = '1;
    cycle();
    check_eq("blk_c3_pvld", 64'(obs_pvld), 64'(!BLK));
    check_eq("blk_c3_pir", 64'(obs_pir), 64'd1);
    bus.u_inv_ready = '0;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      bus.p_rw_ready = m_busy;
      cycle();
      if (obs_rdy[0]) done = 1'b1;
    end
    check_eq("blk_granted", 64'(done), 64'd1);
    bus.p_rw_ready = 1'b0; set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle();

    // Reset while a read and an invalidation are both outstanding.
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h1000, '0, '0);
    bus.p_inv_valid = 1'b1; bus.p_inv_addr = 32'h5000;
    cycle();
    bus.p_inv_valid = 1'b0;
    cycle();
    check_eq("rr_busy", 64'(obs_pvld), 64'd1);
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0400, '0, '0);
    rst = 1'b1; bus.p_rw_ready = 1'b1; bus.u_inv_ready = '1;
    cycle();
    check_eq("rstmid_rdy", 64'(obs_rdy), 64'd0);
    check_eq("rstmid_pir", 64'(obs_pir), 64'd0);
    rst = 1'b0; bus.p_rw_ready = 1'b0; bus.u_inv_ready = '0;
    cycle();
    check_eq("rstpost_pvld", 64'(obs_pvld), 64'd0);
    check_eq("rstpost_rdy", 64'(obs_rdy), 64'd0);
    check_eq("rstpost_iv", 64'(obs_iv), 64'd0);
    check_eq("rstpost_addr", 64'(obs_addr), 64'd0);
    bus.p_rw_ready = 1'b1;
    cycle();
    check_eq("rstpost_first", 64'(obs_rdy), 64'b001);
    check_eq("rstpost_faddr", 64'(obs_addr), 64'h0400);
    bus.p_rw_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0); set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle();

    // Random traffic on both channels with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom % 500 == 0);
      for (int i = 0; i < N; i++) begin
        if (bus.u_rw_valid[i]) begin
          if (obs_rdy[i]) begin
            if ($urandom % 2 == 0) rand_req(i);
            else bus.u_rw_valid[i] = 1'b0;
          end
        end else if ($urandom % 3 == 0) rand_req(i);
      end
      bus.p_rw_ready = m_busy && ($urandom % 3 == 0);
      bus.p_r_data = {$urandom, $urandom};
      if (bus.p_inv_valid ? obs_pir : ($urandom % 4 == 0)) begin
        bus.p_inv_valid = ($urandom % 2 == 0);
        bus.p_inv_addr = ($urandom % 2 == 0) ? 32'h2040 : $urandom;
      end
      bus.u_inv_ready = N'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/system_bus_arbiter.md
SYSTEM_BUS_ARBITER -- requirements
Module: system_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, bus data width; MASK_WIDTH = DATA_WIDTH/8, derived, not overridable.
REQ-003 SHALL have parameter N_USERS, default 2 (L1i, L1d), number of user ports; legal range 2..8.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 u_rw_valid  in  N_USERS  per-user request valid.
REQ-007 u_rw_we / u_w_ce  in  N_USERS each  per-user write enable / write chip enable.
REQ-008 u_rw_addr  in  N_USERS*ADDR_WIDTH  per-user address, user i at slice i.
REQ-009 u_w_mask / u_w_data  in  N_USERS*MASK_WIDTH / N_USERS*DATA_WIDTH  per-user write byte mask / data.
REQ-010 u_rw_ready  out  N_USERS  per-user completion pulse; u_r_data  out  DATA_WIDTH  shared read data.
REQ-011 u_inv_valid  out  N_USERS; u_inv_addr  out  ADDR_WIDTH; u_inv_ready  in  N_USERS  invalidation broadcast channel.
REQ-012 p_rw_valid, p_rw_we, p_w_ce  out  1; p_rw_addr  out  ADDR_WIDTH; p_w_mask, p_w_data  out  MASK_WIDTH, DATA_WIDTH; p_rw_ready  in  1; p_r_data  in  DATA_WIDTH  provider-side SystemBus user signals.
REQ-013 p_inv_valid  in  1; p_inv_addr  in  ADDR_WIDTH; p_inv_ready  out  1  provider invalidation channel.

Function
REQ-014 RW FSM SHALL have states IDLE and BUSY; IDLE -> BUSY when any u_rw_valid is 1 (and not blocked per REQ-027); BUSY -> IDLE on the cycle p_rw_ready = 1.
REQ-015 Arbitration SHALL be round-robin: in IDLE, grant the lowest-index requester at or above (last_grant+1) mod N_USERS, wrapping; last_grant resets to N_USERS-1 so user 0 wins first.
REQ-016 On grant, request fields of the granted user SHALL be registered; p_rw_valid and p_rw_* SHALL be driven from registers during BUSY (one-cycle grant latency, no combinational user-to-provider path).
REQ-017 Users SHALL hold valid and request fields stable until their u_rw_ready; arbiter SHALL NOT re-sample fields in BUSY.
REQ-018 When p_rw_ready = 1 in BUSY, u_rw_ready[grant] SHALL pulse 1 for exactly that cycle, and u_r_data SHALL equal p_r_data that cycle; all other u_rw_ready bits 0.
REQ-019 u_r_data SHALL be don't-care except when some u_rw_ready bit is 1; implementation drives p_r_data through combinationally.
REQ-020 A completed user still holding u_rw_valid in the next IDLE cycle SHALL be treated as a new request, ranked last by round-robin.
REQ-021 Invalidation: when p_inv_valid = 1 and no broadcast pending, latch p_inv_addr, assert u_inv_valid to all users, clear ack mask.
REQ-022 Each user's u_inv_valid bit SHALL drop the cycle after its u_inv_ready is sampled 1; ack mask records it.
REQ-023 p_inv_ready SHALL pulse 1 for one cycle when the ack mask becomes all-ones (including users acking in the same cycle), then broadcast ends; next p_inv_valid accepted the following cycle.
REQ-024 RW and invalidation channels SHALL operate concurrently and independently unless REQ-027 applies.

Reset
REQ-025 On rst: FSM IDLE, last_grant = N_USERS-1, ack mask 0, broadcast idle; all outputs (p_rw_valid, u_rw_ready, u_inv_valid, p_inv_ready) 0, registered data/address outputs 0.
REQ-026 rst asserted mid-transaction SHALL abandon it; no u_rw_ready or p_inv_ready pulse for the abandoned operation; provider is reset together with arbiter.

Configuration
REQ-027 Macro SYSBUS_ARB_INV_BLOCK_EN: when defined, no new grant SHALL be issued while an invalidation broadcast is pending whose address matches (line-aligned to DATA_WIDTH/8 bytes) any requesting user's address; without it, grants ignore invalidation state.

Structure
REQ-028 ArbState enum (IDLE, BUSY) and an RwRequest packed struct (we, ce, addr, mask, data) SHALL live in the shared common package beside the existing SystemBus types.
REQ-029 Round-robin pick SHALL be a sub-module rr_picker (N request bits, last grant in, one-hot/index grant out), purely combinational.

Verification
REQ-030 Single read: user 1 valid, addr 0x1000, we 0; provider ready after 3 cycles with data 0xDEADBEEF_CAFEF00D -> u_rw_ready[1] one pulse, u_r_data matches, p_rw_addr = 0x1000.
REQ-031 Contention: users 0 and 1 request continuously, provider ready every 2nd cycle -> grants alternate 0,1,0,1; no user starved.
REQ-032 Write: user 0 we 1, mask 0x0F, data 0x11223344 -> p_w_mask 0x0F, p_w_data identical, p_w_ce follows u_w_ce.
REQ-033 Invalidation: p_inv_valid addr 0x2040; user 0 acks cycle 1, user 1 acks cycle 4 -> p_inv_ready single pulse at user 1's ack cycle; u_inv_valid[0] low from cycle 2.
REQ-034 Reset mid-BUSY: rst during outstanding read -> all outputs 0 next cycle, no late u_rw_ready; user 0 granted first afterwards.
REQ-035 With SYSBUS_ARB_INV_BLOCK_EN: inv pending at 0x2040, user 0 requests 0x2040 -> no grant until p_inv_ready pulse, then granted; without macro granted immediately.
